// File: rtl/fc_event_pkg.sv
// Shared constants and types for the fabric-controller event queue.
package fc_event_pkg;

    localparam int unsigned FC_EVT_NB_SOURCES = 8;
    localparam int unsigned FC_EVT_ID_WIDTH   = 8;
    localparam int unsigned FC_EVT_FIFO_DEPTH = 4;

    typedef logic [FC_EVT_ID_WIDTH-1:0] evt_id_t;

    // Successor of idx in a ring of n slots.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fc_event_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, then moves the pointer just past the winner.
module fc_event_rr_arb
    import fc_event_pkg::*;
#(
    parameter int unsigned NB_REQ = FC_EVT_NB_SOURCES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_REQ-1:0]         req_i,
    input  logic                      en_i,
    output logic [NB_REQ-1:0]         gnt_o,
    output logic [$clog2(NB_REQ)-1:0] gnt_idx_o,
    output logic                      gnt_valid_o
);

    localparam int unsigned IW = $clog2(NB_REQ);

    logic [IW-1:0] r_prio;
    logic [IW-1:0] w_prio_nxt;
    int unsigned   w_cand;
    logic          w_found;

    // Scan the ring starting at the priority pointer; first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            w_cand = 32'(r_prio) + k;
            if (w_cand >= NB_REQ) begin
                w_cand = w_cand - NB_REQ;
            end
            if (!w_found && en_i && req_i[w_cand[IW-1:0]]) begin
                w_found                 = 1'b1;
                gnt_idx_o               = w_cand[IW-1:0];
                gnt_o[w_cand[IW-1:0]]   = 1'b1;
            end
        end
        gnt_valid_o = w_found;
    end

    // Pointer value to adopt after a grant.
    always_comb begin
        w_prio_nxt = IW'(rr_next(32'(gnt_idx_o), NB_REQ));
    end

    // Priority pointer only moves on a grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio <= '0;
        end else if (gnt_valid_o) begin
            r_prio <= w_prio_nxt;
        end
    end

endmodule

// File: rtl/fc_event_queue.sv
// Event queue feeding the FC event FIFO port: round-robin collection of
// source events into a small FIFO with a valid/fulln output handshake.
module fc_event_queue
    import fc_event_pkg::*;
#(
    parameter int unsigned NB_SOURCES     = FC_EVT_NB_SOURCES,
    parameter int unsigned EVENT_ID_WIDTH = FC_EVT_ID_WIDTH,
    parameter int unsigned FIFO_DEPTH     = FC_EVT_FIFO_DEPTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_SOURCES-1:0]                src_req_i,
    input  logic [NB_SOURCES*EVENT_ID_WIDTH-1:0] src_id_i,
    output logic [NB_SOURCES-1:0]                src_ack_o,
    output logic                                 event_fifo_valid_o,
    output logic [EVENT_ID_WIDTH-1:0]            event_fifo_data_o,
    input  logic                                 event_fifo_fulln_i,
    output logic [$clog2(FIFO_DEPTH):0]          occupancy_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned AW = $clog2(NB_SOURCES);

    logic [EVENT_ID_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [PW:0]               r_count;

    logic                      w_full;
    logic                      w_pop;
    logic                      w_arb_en;
    logic [NB_SOURCES-1:0]     w_gnt;
    logic [AW-1:0]             w_gnt_idx;
    logic                      w_push;
    logic [EVENT_ID_WIDTH-1:0] w_push_id;

    assign w_full    = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_pop     = event_fifo_valid_o & event_fifo_fulln_i;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign w_arb_en  = (~w_full | w_pop) & ~rst_i;
    assign src_ack_o = w_gnt;

    fc_event_rr_arb #(
        .NB_REQ (NB_SOURCES)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (src_req_i),
        .en_i        (w_arb_en),
        .gnt_o       (w_gnt),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_push)
    );

    // Select the granted source's event ID.
    always_comb begin
        w_push_id = '0;
        for (int unsigned i = 0; i < NB_SOURCES; i++) begin
            if (AW'(i) == w_gnt_idx) begin
                w_push_id = src_id_i[i*EVENT_ID_WIDTH +: EVENT_ID_WIDTH];
            end
        end
    end

    // Storage: clear the head on pop, write the new entry on push.
    // When full, push and pop hit the same slot; the write is ordered last so it wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_mem[r_rptr] <= '0;
            end
            if (w_push) begin
                r_mem[r_wptr] <= w_push_id;
            end
        end
    end

    // Pointers and entry count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign event_fifo_valid_o = (r_count != '0);
    assign event_fifo_data_o  = r_mem[r_rptr];
    assign occupancy_o        = r_count;

endmodule

// File: tb/tb_fc_event_queue.sv
// Self-checking bench for fc_event_queue: directed sequences, a vector table
// for back-pressure, and randomized traffic against a queue-based model.
module tb_fc_event_queue;

    localparam int NS = 8;
    localparam int W  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] req;
    logic [NS*W-1:0] ids;
    logic [NS-1:0] ack;
    logic          valid;
    logic [W-1:0]  data;
    logic          fulln;
    logic [2:0]    occ;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int q[$];
    int prio;
    int m_grant;
    bit m_pop;

    always #5 clk = ~clk;

    fc_event_queue #(
        .NB_SOURCES     (NS),
        .EVENT_ID_WIDTH (W),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .src_req_i          (req),
        .src_id_i           (ids),
        .src_ack_o          (ack),
        .event_fifo_valid_o (valid),
        .event_fifo_data_o  (data),
        .event_fifo_fulln_i (fulln),
        .occupancy_o        (occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ids_default();
        for (int i = 0; i < NS; i++) ids[i*W +: W] = W'(8'h10 + i);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '1;
        fulln = 1'b1;
        #1 check("ack_in_reset", 32'(ack), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req   = '0;
        fulln = 1'b0;
        rst   = 1'b0;
        q.delete();
        prio = 0;
    endtask

    function automatic int pick(input logic [NS-1:0] r, input int p);
        for (int k = 0; k < NS; k++) begin
            if (r[(p + k) % NS]) return (p + k) % NS;
        end
        return -1;
    endfunction

    // Expected combinational behaviour for the current inputs and model state.
    task automatic model_check(input string tag);
        bit allowed;
        logic [NS-1:0] exp_ack;
        m_pop   = (q.size() > 0) && fulln;
        allowed = (q.size() < D) || m_pop;
        m_grant = (allowed && !rst) ? pick(req, prio) : -1;
        exp_ack = '0;
        if (m_grant >= 0) exp_ack[m_grant] = 1'b1;
        check({tag, "_ack"},   32'(ack),   32'(exp_ack));
        check({tag, "_valid"}, 32'(valid), 32'(q.size() != 0));
        check({tag, "_data"},  32'(data),  (q.size() != 0) ? q[0] : 0);
        check({tag, "_occ"},   32'(occ),   q.size());
    endtask

    task automatic model_edge();
        if (!rst) begin
            if (m_pop) void'(q.pop_front());
            if (m_grant >= 0) begin
                q.push_back(int'(ids[m_grant*W +: W]));
                prio = (m_grant + 1) % NS;
            end
        end
    endtask

    typedef struct {
        logic [NS-1:0] req;
        logic          fulln;
        logic [NS-1:0] ack;
        logic          valid;
        logic [W-1:0]  data;
        logic [2:0]    occ;
    } vec_t;

    vec_t tbl[12];
    bit   pending[NS];

    initial begin
        rst   = 1'b1;
        req   = '0;
        fulln = 1'b0;
        set_ids_default();

        // Back-pressure / full-with-pop vectors (IDs 0x10+i), starting from reset.
        tbl[0]  = '{8'h3F, 1'b0, 8'h01, 1'b0, 8'h00, 3'd0};
        tbl[1]  = '{8'h3E, 1'b0, 8'h02, 1'b1, 8'h10, 3'd1};
        tbl[2]  = '{8'h3C, 1'b0, 8'h04, 1'b1, 8'h10, 3'd2};
        tbl[3]  = '{8'h38, 1'b0, 8'h08, 1'b1, 8'h10, 3'd3};
        tbl[4]  = '{8'h30, 1'b0, 8'h00, 1'b1, 8'h10, 3'd4};
        tbl[5]  = '{8'h30, 1'b1, 8'h10, 1'b1, 8'h10, 3'd4};
        tbl[6]  = '{8'h20, 1'b1, 8'h20, 1'b1, 8'h11, 3'd4};
        tbl[7]  = '{8'h00, 1'b1, 8'h00, 1'b1, 8'h12, 3'd4};
        tbl[8]  = '{8'h00, 1'b1, 8'h00, 1'b1, 8'h13, 3'd3};
        tbl[9]  = '{8'h00, 1'b1, 8'h00, 1'b1, 8'h14, 3'd2};
        tbl[10] = '{8'h00, 1'b1, 8'h00, 1'b1, 8'h15, 3'd1};
        tbl[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};

        @(negedge clk);

        // Reset state
        do_reset();
        #1;
        check("rst_ack",   32'(ack),   0);
        check("rst_valid", 32'(valid), 0);
        check("rst_data",  32'(data),  0);
        check("rst_occ",   32'(occ),   0);

        // Single event from source 3
        next_cycle();
        req = 8'h08;
        ids[3*W +: W] = 8'h2A;
        fulln = 1'b1;
        #1;
        check("single_ack",   32'(ack),   32'h08);
        check("single_valid0", 32'(valid), 0);
        next_cycle();
        req = '0;
        #1;
        check("single_valid", 32'(valid), 1);
        check("single_data",  32'(data),  32'h2A);
        check("single_occ1",  32'(occ),   1);
        check("single_noack", 32'(ack),   0);
        next_cycle();
        #1;
        check("single_drain_valid", 32'(valid), 0);
        check("single_drain_occ",   32'(occ),   0);
        check("single_drain_data",  32'(data),  0);
        set_ids_default();

        // Round-robin with all sources requesting continuously
        next_cycle();
        do_reset();
        req   = '1;
        fulln = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("rr_ack", 32'(ack), 32'(1) << (c % NS));
            check("rr_valid", 32'(valid), 32'(c > 0));
            if (c > 0) begin
                check("rr_data", 32'(data), 32'h10 + ((c - 1) % NS));
                check("rr_occ",  32'(occ),  1);
            end
            next_cycle();
        end
        req = '0;
        #1 check("rr_tail_data", 32'(data), 32'h11);
        next_cycle();
        #1 check("rr_drained_occ", 32'(occ), 0);

        // Back-pressure table
        next_cycle();
        do_reset();
        foreach (tbl[i]) begin
            req   = tbl[i].req;
            fulln = tbl[i].fulln;
            #1;
            check($sformatf("bp%0d_ack", i),   32'(ack),   32'(tbl[i].ack));
            check($sformatf("bp%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            check($sformatf("bp%0d_data", i),  32'(data),  32'(tbl[i].data));
            check($sformatf("bp%0d_occ", i),   32'(occ),   32'(tbl[i].occ));
            next_cycle();
        end

        // Reset in the middle of operation with a request pending
        do_reset();
        fulln = 1'b0;
        req = 8'h01; next_cycle();
        req = 8'h02; next_cycle();
        req = 8'h04; next_cycle();
        req = '0;
        #1;
        check("mid_occ3",   32'(occ),   3);
        check("mid_valid1", 32'(valid), 1);
        req = 8'h20;
        ids[5*W +: W] = 8'h55;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_ack",   32'(ack),   0);
        check("mid_rst_occ",   32'(occ),   0);
        check("mid_rst_data",  32'(data),  0);
        next_cycle();
        rst = 1'b0;
        #1 check("mid_rel_ack", 32'(ack), 32'h20);
        next_cycle();
        req = '0;
        #1;
        check("mid_post_valid", 32'(valid), 1);
        check("mid_post_data",  32'(data),  32'h55);
        check("mid_post_occ",   32'(occ),   1);
        next_cycle();
        #1;
        check("mid_hold_occ",  32'(occ),  1);
        check("mid_hold_data", 32'(data), 32'h55);

        // Randomized traffic against the reference model
        next_cycle();
        do_reset();
        foreach (pending[i]) pending[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NS; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    ids[i*W +: W] = W'($urandom);
                end
                req[i] = pending[i];
            end
            fulln = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                q.delete();
                prio = 0;
                #1 model_check("rnd_rst");
                next_cycle();
                rst = 1'b0;
            end else begin
                #1 model_check("rnd");
                @(posedge clk);
                model_edge();
                if (m_grant >= 0) pending[m_grant] = 1'b0;
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc_event_queue.md
# fc_event_queue

Upstream feeder for the fabric controller's event FIFO port. Collects event requests from up to NB_SOURCES SoC peripherals (each offering an event ID with a req/ack handshake), arbitrates them round-robin, and buffers them in a small FIFO. It presents the buffered IDs to the FC subsystem on its `event_fifo_valid` / `event_fifo_data` / `event_fifo_fulln` interface. No event is ever dropped: sources hold their request until acknowledged.

## Interface
Parameters:
- NB_SOURCES, 8: number of requesting peripherals (≥2).
- EVENT_ID_WIDTH, 8: width of an event ID; matches the FC event port.
- FIFO_DEPTH, 4: buffer entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- src_req_i  in  NB_SOURCES  per-source request; held high until the matching ack.
- src_id_i  in  NB_SOURCES×EVENT_ID_WIDTH  per-source event ID; stable while req is high.
- src_ack_o  out  NB_SOURCES  one-hot ack; ID is captured in the same cycle.
- event_fifo_valid_o  out  1  head entry valid (to FC `event_fifo_valid_i`).
- event_fifo_data_o  out  EVENT_ID_WIDTH  head entry ID (to FC `event_fifo_data_i`).
- event_fifo_fulln_i  in  1  FC can accept (from FC `event_fifo_fulln_o`).
- occupancy_o  out  clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- **Pop**: a pop occurs when `event_fifo_valid_o & event_fifo_fulln_i` at a rising edge. The head is removed and the read pointer advances.
- **Push**:
  - Allowed in a cycle when `count < FIFO_DEPTH`, or when a pop occurs in the same cycle.
  - When allowed and at least one req is high, the arbiter grants exactly one source.
  - The granted source sees its `src_ack_o` bit high combinationally.
  - Its ID is written at the write pointer on the next edge.
- **Round-robin arbitration**:
  - A priority pointer `prio` (reset 0) selects the first requesting source at or after `prio`, wrapping modulo NB_SOURCES.
  - After a grant to source i, `prio` becomes (i+1) mod NB_SOURCES.
  - `prio` does not change without a grant.
- **Counter update**: `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- **Pointers**: read and write pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally.
- **Outputs**:
  - `event_fifo_valid_o = (count != 0)`.
  - `event_fifo_data_o` = memory at the read pointer; it is 0 when empty because entries are cleared on pop.
- **Full, no pop**: no ack is issued, and requests stay pending.
- **Empty**: pop is impossible because valid is 0; `fulln_i` is ignored.
- **Reset**:
  - Asserting `rst_i`, including mid-transfer, immediately clears count, pointers, `prio` and memory.
  - While reset is asserted, all `src_ack_o` bits are forced to 0.
  - Pending sources re-request after reset release.

## Timing
- Reset values: `src_ack_o=0`, `event_fifo_valid_o=0`, `event_fifo_data_o=0`, `occupancy_o=0`.
- Latency: a req/ack in cycle t with the FIFO empty gives `event_fifo_valid_o=1` with that ID from cycle t+1. Minimum source-to-FC latency is 1 cycle.
- Throughput: one push and one pop per cycle, so it sustains 1 event/cycle when `fulln_i` is held high.
- `src_ack_o` is combinational from `src_req_i`, count, `prio` and `fulln_i`; the source must not assume a registered ack.
- A source may deassert req only in the cycle after its ack.

## Structure
- Shared package `fc_event_pkg`:
  - default constants `FC_EVT_NB_SOURCES`, `FC_EVT_ID_WIDTH`, `FC_EVT_FIFO_DEPTH`;
  - typedef `evt_id_t` (logic [EVENT_ID_WIDTH-1:0]).
- One sub-module, `fc_event_rr_arb`: a parameterised round-robin arbiter. It takes a req vector and an enable, and returns a one-hot grant plus the grant index; it owns the `prio` register.
- The top level holds the FIFO memory, pointers, count and handshake logic.

## Test plan
- **Reset state**: apply reset, then release with all req low → all outputs 0, no ack, occupancy 0.
- **Single event**: src 3 requests ID 0x2A with `fulln_i=1` → ack[3] in cycle t; valid=1, data=0x2A at t+1; popped at t+1 edge; occupancy returns to 0.
- **Round-robin**: all 8 sources request continuously (IDs 0x10+i), `fulln_i=1` → grants 0,1,…,7,0 in order, one per cycle; the FC side sees the IDs in the same order.
- **Full back-pressure**: `fulln_i=0`, sources 0–5 request → 4 acks (src 0–3), occupancy 4, src 4/5 held. Raise `fulln_i`: pops 0x10..0x13 and concurrent pushes of src 4,5; occupancy never exceeds 4.
- **Full with pop**: at occupancy 4, pop and a req in the same cycle → ack granted, occupancy stays 4.
- **Reset mid-operation**: assert `rst_i` at occupancy 3 with req pending → valid drops to 0 immediately, ack forced 0. After release, the pending source is acked and the FIFO holds only that ID.
